// File: rtl/operand_entry_ctrl_pkg.sv
// Shared definitions for operand entry sequencing: state encodings and
// default timing parameters. The game FSM imports the same package to
// decode Phase.
package operand_entry_ctrl_pkg;

    // 10 s entry window at 50 MHz; the counter must hold TIMEOUT_CYCLES-1.
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 500_000_000;
    localparam int unsigned DEFAULT_CNT_W          = 29;

    // Phase encodings; 2'b11 is never entered and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT_A = 2'b01,
        ST_WAIT_B = 2'b10,
        ST_UNUSED = 2'b11
    } state_t;

endpackage

// File: rtl/operand_entry_ctrl_entry_timer.sv
// Entry-window timer: counts cycles while enabled, returns to zero on
// Clear, and flags the last cycle of the window (count == TIMEOUT_CYCLES-1).
// The controller clears it on every state change, so it never wraps.
module entry_timer
    import operand_entry_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Terminal
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Cycle counter; Clear has priority over Enable.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of its neighbours, independent of evaluation order.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count <= '0;
        end else if (Clear) begin
            count <= '0;
        end else if (Enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign Terminal = (count == LAST_COUNT);

endmodule

// File: rtl/operand_entry_ctrl.sv
// Operand entry controller: turns successive Load presses into one-cycle
// load strobes for operand A then operand B, and aborts the round if a
// press does not arrive within the entry window.
module operand_entry_ctrl
    import operand_entry_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       LoadPress,
    output logic       LoadA,
    output logic       LoadB,
    output logic       EntryDone,
    output logic       TimedOut,
    output logic       Busy,
    output logic [1:0] Phase
);

    state_t state;
    state_t state_next;
    logic   load_a_next;
    logic   load_b_next;
    logic   entry_done_next;
    logic   timed_out_next;
    logic   busy;
    logic   timer_clear;
    logic   timer_terminal;

    assign busy = (state == ST_WAIT_A) || (state == ST_WAIT_B);

    // Timer restarts from zero on entering any WAIT state and stays at zero
    // outside them, so the first WAIT cycle always sees count 0.
    assign timer_clear = !busy || (state_next != state);

    entry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_entry_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .Clear    (timer_clear),
        .Enable   (busy),
        .Terminal (timer_terminal)
    );

    // Next-state and strobe decode; a press always beats the timeout.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        load_a_next     = 1'b0;
        load_b_next     = 1'b0;
        entry_done_next = 1'b0;
        timed_out_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_next = ST_WAIT_A;
                end
            end
            ST_WAIT_A: begin
                if (LoadPress) begin
                    state_next  = ST_WAIT_B;
                    load_a_next = 1'b1;
                end else if (timer_terminal) begin
                    state_next     = ST_IDLE;
                    timed_out_next = 1'b1;
                end
            end
            ST_WAIT_B: begin
                if (LoadPress) begin
                    state_next      = ST_IDLE;
                    load_b_next     = 1'b1;
                    entry_done_next = 1'b1;
                end else if (timer_terminal) begin
                    state_next     = ST_IDLE;
                    timed_out_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered strobes.
    // NOTE: reset clears the strobes as well as the state, so a round
    // aborted by reset never emits a stray load or timeout pulse.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            LoadA     <= 1'b0;
            LoadB     <= 1'b0;
            EntryDone <= 1'b0;
            TimedOut  <= 1'b0;
        end else begin
            state     <= state_next;
            LoadA     <= load_a_next;
            LoadB     <= load_b_next;
            EntryDone <= entry_done_next;
            TimedOut  <= timed_out_next;
        end
    end

    assign Phase = state;
    assign Busy  = busy;

endmodule
